// File: rtl/src_ctrl_pkg.sv
// rtl/src_ctrl_pkg.sv - shared states and constants for the SRC control-transfer sequencer
package src_ctrl_pkg;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_BR  = 5'b10011;
    localparam logic [4:0] OP_JR  = 5'b10100;
    localparam logic [4:0] OP_JAL = 5'b10101;

    // C2 branch condition field; evaluated by the CON logic in the datapath
    localparam logic [1:0] C2_ZR = 2'b00;
    localparam logic [1:0] C2_NZ = 2'b01;
    localparam logic [1:0] C2_PL = 2'b10;
    localparam logic [1:0] C2_MI = 2'b11;

    localparam logic [1:0] FLT_NONE        = 2'b00;
    localparam logic [1:0] FLT_MEM_TIMEOUT = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL_OP  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_BR_T3,
        S_BR_T4,
        S_BR_T5,
        S_BR_T6,
        S_JR_T3,
        S_JAL_T3,
        S_JAL_T4,
        S_FAULT
    } seq_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags the last allowed one
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic Clock,
    input  logic clear,
    input  logic en,
    input  logic done,
    output logic first,
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (!en || done || timeout) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign first   = en && (count == '0);
    // Asserted on the final permitted wait cycle; a done in that cycle still wins upstream
    assign timeout = en && (count == LAST);

endmodule

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - hardwired fetch/branch/jr/jal control sequencer for the SRC datapath
module branch_sequencer
    import src_ctrl_pkg::*;
#(
    parameter int               DATA_WIDTH  = 32,
    parameter int               OPC_W       = 5,
    parameter logic [OPC_W-1:0] ADD_OP      = OP_ADD,
    parameter logic [OPC_W-1:0] BR_OP       = OP_BR,
    parameter logic [OPC_W-1:0] JR_OP       = OP_JR,
    parameter logic [OPC_W-1:0] JAL_OP      = OP_JAL,
    parameter int               MEM_TIMEOUT = 15
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] ir,
    input  logic                  con_ff_bit,
    input  logic                  memory_done,
    output logic                  PCout,
    output logic                  IncPC,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  Zlo_out,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  MDRout,
    output logic                  IRin,
    output logic                  Gra,
    output logic                  Rout,
    output logic                  Rin,
    output logic                  CONin,
    output logic                  Yin,
    output logic                  Cout,
    output logic                  Mem_Read,
    output logic                  Mem_enable512x32,
    output logic                  R15_sel,
    output logic [OPC_W-1:0]      alu_op,
    output logic                  busy,
    output logic                  instr_done,
    output logic                  branch_taken,
    output logic                  fault,
    output logic [1:0]            fault_code
);

    seq_state_t       state, state_next;
    logic             t1_first, t1_timeout;
    logic             fault_set;
    logic [1:0]       fault_code_next;
    logic [OPC_W-1:0] opcode;
    logic             unused_ir;

    assign opcode    = ir[DATA_WIDTH-1 -: OPC_W];
    assign unused_ir = ^ir[DATA_WIDTH-OPC_W-1:0];

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .Clock   (Clock),
        .clear   (clear),
        .en      (state == S_T1),
        .done    (memory_done),
        .first   (t1_first),
        .timeout (t1_timeout)
    );

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        fault_set        = 1'b0;
        fault_code_next  = FLT_NONE;
        PCout            = 1'b0;
        IncPC            = 1'b0;
        MARin            = 1'b0;
        Zin              = 1'b0;
        Zlo_out          = 1'b0;
        PCin             = 1'b0;
        MDRin            = 1'b0;
        MDRout           = 1'b0;
        IRin             = 1'b0;
        Gra              = 1'b0;
        Rout             = 1'b0;
        Rin              = 1'b0;
        CONin            = 1'b0;
        Yin              = 1'b0;
        Cout             = 1'b0;
        Mem_Read         = 1'b0;
        Mem_enable512x32 = 1'b0;
        R15_sel          = 1'b0;
        instr_done       = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_next = S_T0;
            end
            S_T0: begin
                PCout      = 1'b1;
                IncPC      = 1'b1;
                MARin      = 1'b1;
                Zin        = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                MDRin            = 1'b1;
                Mem_Read         = 1'b1;
                Mem_enable512x32 = 1'b1;
                // PC+1 is latched once, no matter how long memory stalls
                Zlo_out          = t1_first;
                PCin             = t1_first;
                if (memory_done) begin
                    state_next = S_T2;
                end else if (t1_timeout) begin
                    state_next      = S_FAULT;
                    fault_set       = 1'b1;
                    fault_code_next = FLT_MEM_TIMEOUT;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                if (opcode == BR_OP) begin
                    state_next = S_BR_T3;
                end else if (opcode == JR_OP) begin
                    state_next = S_JR_T3;
                end else if (opcode == JAL_OP) begin
                    state_next = S_JAL_T3;
                end else begin
                    state_next      = S_FAULT;
                    fault_set       = 1'b1;
                    fault_code_next = FLT_ILLEGAL_OP;
                end
            end
            S_BR_T3: begin
                Gra        = 1'b1;
                Rout       = 1'b1;
                CONin      = 1'b1;
                state_next = S_BR_T4;
            end
            S_BR_T4: begin
                PCout      = 1'b1;
                Yin        = 1'b1;
                state_next = S_BR_T5;
            end
            S_BR_T5: begin
                Cout       = 1'b1;
                Zin        = 1'b1;
                state_next = S_BR_T6;
            end
            S_BR_T6: begin
                Zlo_out    = 1'b1;
                PCin       = con_ff_bit;
                instr_done = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_JR_T3: begin
                Gra        = 1'b1;
                Rout       = 1'b1;
                PCin       = 1'b1;
                instr_done = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_JAL_T3: begin
                R15_sel    = 1'b1;
                PCout      = 1'b1;
                Rin        = 1'b1;
                state_next = S_JAL_T4;
            end
            S_JAL_T4: begin
                Gra        = 1'b1;
                Rout       = 1'b1;
                PCin       = 1'b1;
                instr_done = 1'b1;
                state_next = run ? S_T0 : S_IDLE;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_FAULT);

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            branch_taken <= 1'b0;
            fault        <= 1'b0;
            fault_code   <= FLT_NONE;
            alu_op       <= '0;
        end else begin
            if (state == S_BR_T6) begin
                branch_taken <= con_ff_bit;
            end else if (state == S_JR_T3 || state == S_JAL_T4) begin
                branch_taken <= 1'b1;
            end
            if (fault_set) begin
                fault      <= 1'b1;
                fault_code <= fault_code_next;
            end
            // ADD stays on the ALU through the PC update and drops at the next fetch
            if (state_next == S_BR_T5) begin
                alu_op <= ADD_OP;
            end else if (state_next == S_T0) begin
                alu_op <= '0;
            end
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed self-checking bench for branch_sequencer
module tb_branch_sequencer;
    import src_ctrl_pkg::*;

    logic        Clock = 1'b0;
    logic        clear, run, con_ff_bit, memory_done;
    logic [31:0] ir;
    logic        PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin;
    logic        Gra, Rout, Rin, CONin, Yin, Cout, Mem_Read, Mem_enable512x32, R15_sel;
    logic [4:0]  alu_op;
    logic        busy, instr_done, branch_taken, fault;
    logic [1:0]  fault_code;

    int vectors    = 0;
    int miscompares = 0;

    // {PCout,IncPC,MARin,Zin,Zlo_out,PCin,MDRin,MDRout,IRin,Gra,Rout,Rin,CONin,Yin,Cout,Mem_Read,Mem_en,R15_sel}
    localparam logic [17:0] ST_NONE   = 18'h00000;
    localparam logic [17:0] ST_T0     = 18'h3C000;
    localparam logic [17:0] ST_T1A    = 18'h03806;
    localparam logic [17:0] ST_T1B    = 18'h00806;
    localparam logic [17:0] ST_T2     = 18'h00600;
    localparam logic [17:0] ST_BR_T3  = 18'h001A0;
    localparam logic [17:0] ST_BR_T4  = 18'h20010;
    localparam logic [17:0] ST_BR_T5  = 18'h04008;
    localparam logic [17:0] ST_BR_T6T = 18'h03000;
    localparam logic [17:0] ST_BR_T6N = 18'h02000;
    localparam logic [17:0] ST_JR_T3  = 18'h01180;
    localparam logic [17:0] ST_JAL_T3 = 18'h20041;
    localparam logic [17:0] ST_JAL_T4 = 18'h01180;

    branch_sequencer dut (
        .Clock            (Clock),
        .clear            (clear),
        .run              (run),
        .ir               (ir),
        .con_ff_bit       (con_ff_bit),
        .memory_done      (memory_done),
        .PCout            (PCout),
        .IncPC            (IncPC),
        .MARin            (MARin),
        .Zin              (Zin),
        .Zlo_out          (Zlo_out),
        .PCin             (PCin),
        .MDRin            (MDRin),
        .MDRout           (MDRout),
        .IRin             (IRin),
        .Gra              (Gra),
        .Rout             (Rout),
        .Rin              (Rin),
        .CONin            (CONin),
        .Yin              (Yin),
        .Cout             (Cout),
        .Mem_Read         (Mem_Read),
        .Mem_enable512x32 (Mem_enable512x32),
        .R15_sel          (R15_sel),
        .alu_op           (alu_op),
        .busy             (busy),
        .instr_done       (instr_done),
        .branch_taken     (branch_taken),
        .fault            (fault),
        .fault_code       (fault_code)
    );

    always #5 Clock = ~Clock;

    function automatic logic [17:0] strobes();
        return {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin,
                Gra, Rout, Rin, CONin, Yin, Cout, Mem_Read, Mem_enable512x32, R15_sel};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Entered with the DUT in T0; leaves it in the state selected by the T3 decode
    task automatic do_fetch(input int wait_n, input logic [4:0] opc, input logic [1:0] c2);
        int pcin_n;
        pcin_n = 0;
        check("t0_strobes", 32'(strobes()), 32'(ST_T0));
        check("t0_busy", 32'(busy), 32'd1);
        check("t0_alu_op", 32'(alu_op), 32'd0);
        ir = {opc, 5'd0, 5'd5, 15'd0, c2};
        step();
        for (int k = 1; k <= wait_n; k++) begin
            check("t1_strobes", 32'(strobes()), (k == 1) ? 32'(ST_T1A) : 32'(ST_T1B));
            if (PCin) pcin_n++;
            memory_done = (k == wait_n);
            step();
        end
        memory_done = 1'b0;
        check("t1_pcin_once", 32'(pcin_n), 32'd1);
        check("t2_strobes", 32'(strobes()), 32'(ST_T2));
        step();
        check("t3_strobes", 32'(strobes()), 32'(ST_NONE));
        step();
    endtask

    task automatic do_branch(input logic con);
        check("br_t3_strobes", 32'(strobes()), 32'(ST_BR_T3));
        step();
        check("br_t4_strobes", 32'(strobes()), 32'(ST_BR_T4));
        step();
        check("br_t5_strobes", 32'(strobes()), 32'(ST_BR_T5));
        check("br_t5_alu_op", 32'(alu_op), 32'(OP_ADD));
        step();
        con_ff_bit = con;
        #1;
        check("br_t6_strobes", 32'(strobes()), con ? 32'(ST_BR_T6T) : 32'(ST_BR_T6N));
        check("br_t6_done", 32'(instr_done), 32'd1);
        check("br_t6_alu_op", 32'(alu_op), 32'(OP_ADD));
        step();
        check("br_taken", 32'(branch_taken), 32'(con));
        check("br_done_drop", 32'(instr_done), 32'd0);
    endtask

    initial begin
        clear       = 1'b0;
        run         = 1'b0;
        con_ff_bit  = 1'b0;
        memory_done = 1'b0;
        ir          = '0;
        #3;
        check("rst_strobes", 32'(strobes()), 32'(ST_NONE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({instr_done, branch_taken, fault, fault_code}), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);

        @(negedge Clock);
        clear = 1'b1;
        run   = 1'b1;
        step();

        // brzr taken, single-cycle memory
        do_fetch(1, OP_BR, C2_ZR);
        do_branch(1'b1);

        // jr with a 5-cycle memory stall
        do_fetch(5, OP_JR, C2_ZR);
        check("jr_t3_strobes", 32'(strobes()), 32'(ST_JR_T3));
        check("jr_t3_done", 32'(instr_done), 32'd1);
        step();
        check("jr_taken", 32'(branch_taken), 32'd1);

        // brnz not taken; memory_done lands on the timeout cycle and must win
        do_fetch(15, OP_BR, C2_NZ);
        do_branch(1'b0);

        // jal; run drops mid-instruction, instruction still completes then idles
        do_fetch(1, OP_JAL, C2_ZR);
        check("jal_t3_strobes", 32'(strobes()), 32'(ST_JAL_T3));
        run = 1'b0;
        step();
        check("jal_t4_strobes", 32'(strobes()), 32'(ST_JAL_T4));
        check("jal_t4_done", 32'(instr_done), 32'd1);
        step();
        check("jal_taken", 32'(branch_taken), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_strobes", 32'(strobes()), 32'(ST_NONE));
        run = 1'b1;
        step();

        // asynchronous clear during BR_T5
        do_fetch(1, OP_BR, C2_ZR);
        step();
        step();
        check("pre_clr_alu_op", 32'(alu_op), 32'(OP_ADD));
        #2;
        clear = 1'b0;
        #1;
        check("clr_strobes", 32'(strobes()), 32'(ST_NONE));
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_alu_op", 32'(alu_op), 32'd0);
        check("clr_taken", 32'(branch_taken), 32'd0);
        @(negedge Clock);
        clear = 1'b1;
        step();

        // memory never answers: fault after exactly MEM_TIMEOUT T1 cycles
        check("to_t0_strobes", 32'(strobes()), 32'(ST_T0));
        step();
        for (int k = 1; k <= 15; k++) begin
            check("to_t1_strobes", 32'(strobes()), (k == 1) ? 32'(ST_T1A) : 32'(ST_T1B));
            step();
        end
        check("to_strobes", 32'(strobes()), 32'(ST_NONE));
        check("to_fault", 32'(fault), 32'd1);
        check("to_code", 32'(fault_code), 32'(FLT_MEM_TIMEOUT));
        check("to_busy", 32'(busy), 32'd0);
        repeat (10) step();
        check("to_sticky_fault", 32'(fault), 32'd1);
        check("to_sticky_code", 32'(fault_code), 32'(FLT_MEM_TIMEOUT));
        check("to_sticky_strobes", 32'(strobes()), 32'(ST_NONE));
        @(negedge Clock);
        clear = 1'b0;
        #1;
        check("to_clr_fault", 32'({fault, fault_code}), 32'd0);
        @(negedge Clock);
        clear = 1'b1;
        step();

        // illegal opcode
        do_fetch(1, 5'b11111, C2_ZR);
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_code", 32'(fault_code), 32'(FLT_ILLEGAL_OP));
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_strobes", 32'(strobes()), 32'(ST_NONE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
